// File: rtl/mc_control_fsm.sv
// Main control FSM of the multicycle MIPS core: Moore decode of all datapath enables and selects.
// Optional MC_ILLEGAL_OP_TRAP_EN sends unknown opcodes to a sticky HALT state instead of FETCH.
module mc_control_fsm #(
  parameter int unsigned STATE_W = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [5:0]         opcode_i6,
  input  logic               zero_i,
  output logic               pc_we_o,
  output logic               instr_or_data_o,
  output logic               instr_we_o,
  output logic               mem_we_o,
  output logic               enable_wrf_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               a_alu_input_o,
  output logic [1:0]         b_alu_input_o2,
  output logic [1:0]         alu_alt_ctrl_o2,
  output logic [1:0]         pc_src_o2,
  output logic               halted_o,
  output logic [STATE_W-1:0] state_o
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StExec   = 4'd6,
    StAluWb  = 4'd7,
    StBranch = 4'd8,
    StAddiEx = 4'd9,
    StAddiWb = 4'd10,
    StJump   = 4'd11,
    StHalt   = 4'd12
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;

  state_e state_q, state_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = StFetch;
    case (state_q)
      StFetch:  state_d = StDecode;
      StDecode: begin
        case (opcode_i6)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtype:    state_d = StExec;
          OpBeq:      state_d = StBranch;
          OpAddi:     state_d = StAddiEx;
          OpJ:        state_d = StJump;
`ifdef MC_ILLEGAL_OP_TRAP_EN
          default:    state_d = StHalt;
`else
          default:    state_d = StFetch;
`endif
        endcase
      end
      // IR is only written in FETCH, so the opcode is still valid here.
      StMemAdr: state_d = (opcode_i6 == OpSw) ? StMemWr : StMemRd;
      StMemRd:  state_d = StMemWb;
      StExec:   state_d = StAluWb;
      StAddiEx: state_d = StAddiWb;
`ifdef MC_ILLEGAL_OP_TRAP_EN
      StHalt:   state_d = StHalt;
`endif
      default:  state_d = StFetch;
    endcase
  end

  always_comb begin
    pc_we_o         = 1'b0;
    instr_or_data_o = 1'b0;
    instr_we_o      = 1'b0;
    mem_we_o        = 1'b0;
    enable_wrf_o    = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    a_alu_input_o   = 1'b0;
    b_alu_input_o2  = 2'b00;
    alu_alt_ctrl_o2 = 2'b00;
    pc_src_o2       = 2'b00;
    halted_o        = 1'b0;
    case (state_q)
      StFetch: begin
        instr_we_o     = 1'b1;
        b_alu_input_o2 = 2'b01;
        pc_we_o        = 1'b1;
      end
      StDecode: b_alu_input_o2 = 2'b11;
      StMemAdr, StAddiEx: begin
        a_alu_input_o  = 1'b1;
        b_alu_input_o2 = 2'b10;
      end
      StMemRd: instr_or_data_o = 1'b1;
      StMemWb: begin
        enable_wrf_o = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      StMemWr: begin
        instr_or_data_o = 1'b1;
        mem_we_o        = 1'b1;
      end
      StExec: begin
        a_alu_input_o   = 1'b1;
        alu_alt_ctrl_o2 = 2'b10;
      end
      StAluWb: begin
        enable_wrf_o = 1'b1;
        reg_dst_o    = 1'b1;
      end
      // Branch-taken PC write is the only combinational input-to-output path.
      StBranch: begin
        a_alu_input_o   = 1'b1;
        alu_alt_ctrl_o2 = 2'b01;
        pc_src_o2       = 2'b01;
        pc_we_o         = zero_i;
      end
      StAddiWb: enable_wrf_o = 1'b1;
      StJump: begin
        pc_src_o2 = 2'b10;
        pc_we_o   = 1'b1;
      end
`ifdef MC_ILLEGAL_OP_TRAP_EN
      StHalt: halted_o = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state_o = STATE_W'(state_q);

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed vector table, corner sequences, and random
// instruction streams checked against an instruction-level path model.
module tb_mc_control_fsm;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [5:0] opcode_i6;
  logic       zero_i;
  logic       pc_we_o, instr_or_data_o, instr_we_o, mem_we_o, enable_wrf_o;
  logic       reg_dst_o, mem_to_reg_o, a_alu_input_o, halted_o;
  logic [1:0] b_alu_input_o2, alu_alt_ctrl_o2, pc_src_o2;
  logic [3:0] state_o;

  mc_control_fsm #(.STATE_W(4)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .opcode_i6(opcode_i6), .zero_i(zero_i),
    .pc_we_o(pc_we_o), .instr_or_data_o(instr_or_data_o), .instr_we_o(instr_we_o),
    .mem_we_o(mem_we_o), .enable_wrf_o(enable_wrf_o), .reg_dst_o(reg_dst_o),
    .mem_to_reg_o(mem_to_reg_o), .a_alu_input_o(a_alu_input_o),
    .b_alu_input_o2(b_alu_input_o2), .alu_alt_ctrl_o2(alu_alt_ctrl_o2),
    .pc_src_o2(pc_src_o2), .halted_o(halted_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  // {halted, pc_we, iod, iwe, mwe, wrf, reg_dst, m2r, a_sel, b_sel[2], alu[2], pc_src[2]}
  logic [14:0] dut_out;
  assign dut_out = {halted_o, pc_we_o, instr_or_data_o, instr_we_o, mem_we_o, enable_wrf_o,
                    reg_dst_o, mem_to_reg_o, a_alu_input_o, b_alu_input_o2, alu_alt_ctrl_o2,
                    pc_src_o2};

  localparam logic [5:0] OpR = 6'b000000, OpJ = 6'b000010, OpBeq = 6'b000100;
  localparam logic [5:0] OpAddi = 6'b001000, OpLw = 6'b100011, OpSw = 6'b101011;
  localparam logic [5:0] OpIll = 6'b111111;

  int tests = 0;
  int fails = 0;

  function automatic logic [14:0] exp_out(input int st, input logic z);
    case (st)
      0:       return 15'b0_1_0_1_0_0_0_0_0_01_00_00;
      1:       return 15'b0_0_0_0_0_0_0_0_0_11_00_00;
      2, 9:    return 15'b0_0_0_0_0_0_0_0_1_10_00_00;
      3:       return 15'b0_0_1_0_0_0_0_0_0_00_00_00;
      4:       return 15'b0_0_0_0_0_1_0_1_0_00_00_00;
      5:       return 15'b0_0_1_0_1_0_0_0_0_00_00_00;
      6:       return 15'b0_0_0_0_0_0_0_0_1_00_10_00;
      7:       return 15'b0_0_0_0_0_1_1_0_0_00_00_00;
      8:       return {1'b0, z, 13'b0_0_0_0_0_0_1_00_01_01};
      10:      return 15'b0_0_0_0_0_1_0_0_0_00_00_00;
      11:      return 15'b0_1_0_0_0_0_0_0_0_00_00_10;
      12:      return 15'b1_0_0_0_0_0_0_0_0_00_00_00;
      default: return 15'b0;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs for the current cycle, check, then advance to the next negedge.
  task automatic apply(input logic [5:0] op, input logic z, input int st);
    opcode_i6 = op;
    zero_i    = z;
    #1;
    chk($sformatf("state op=%b", op), int'(state_o), st);
    chk($sformatf("outs st=%0d z=%0b", st, z), int'(dut_out), int'(exp_out(st, z)));
    @(negedge clk_i);
  endtask

  task automatic pulse_reset();
    reset_i = 1'b1;
    #1;
    chk("async reset state", int'(state_o), 0);
    chk("reset outs", int'(dut_out), int'(exp_out(0, 1'b0)));
    @(negedge clk_i);
    reset_i = 1'b0;
  endtask

  // Expected state walk of one instruction, from the per-instruction latency rules.
  function automatic void inst_path(input logic [5:0] op, output int p[$]);
    p = {0, 1};
    case (op)
      OpLw:    p = {p, 2, 3, 4};
      OpSw:    p = {p, 2, 5};
      OpR:     p = {p, 6, 7};
      OpAddi:  p = {p, 9, 10};
      OpBeq:   p = {p, 8};
      OpJ:     p = {p, 11};
      default: ;
    endcase
  endfunction

  typedef struct {
    logic [5:0] op;
    logic       z;
    int         st;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic [5:0] op, input logic z, input int st);
    vec_t v;
    v.op = op; v.z = z; v.st = st;
    vecs.push_back(v);
  endfunction

  initial begin
    int   p[$];
    logic [5:0] ops[7];

    add(OpLw, 0, 0);   add(OpLw, 0, 1);   add(OpLw, 0, 2);   add(OpLw, 1, 3);  add(OpLw, 0, 4);
    add(OpSw, 0, 0);   add(OpSw, 1, 1);   add(OpSw, 0, 2);   add(OpSw, 0, 5);
    add(OpBeq, 0, 0);  add(OpBeq, 0, 1);  add(OpBeq, 1, 8);
    add(OpBeq, 1, 0);  add(OpBeq, 1, 1);  add(OpBeq, 0, 8);
    add(OpR, 0, 0);    add(OpR, 0, 1);    add(OpR, 1, 6);    add(OpR, 0, 7);
    add(OpAddi, 0, 0); add(OpAddi, 0, 1); add(OpAddi, 0, 9); add(OpAddi, 1, 10);
    add(OpJ, 0, 0);    add(OpJ, 0, 1);    add(OpJ, 0, 11);

    reset_i   = 1'b1;
    opcode_i6 = OpLw;
    zero_i    = 1'b0;
    #2;
    chk("reset state", int'(state_o), 0);
    chk("reset outs", int'(dut_out), int'(exp_out(0, 1'b0)));
    chk("reset halted", int'(halted_o), 0);
    @(negedge clk_i);
    reset_i = 1'b0;

    foreach (vecs[i]) apply(vecs[i].op, vecs[i].z, vecs[i].st);

    // Reset asserted between edges while in JUMP must take effect immediately.
    apply(OpJ, 0, 0);
    apply(OpJ, 0, 1);
    #1;
    chk("in jump", int'(state_o), 11);
    chk("jump pc_we", int'(pc_we_o), 1);
    pulse_reset();
    apply(OpJ, 0, 0);
    apply(OpJ, 0, 1);
    apply(OpJ, 0, 11);

    apply(OpIll, 0, 0);
    apply(OpIll, 0, 1);
`ifdef MC_ILLEGAL_OP_TRAP_EN
    for (int i = 0; i < 10; i++) apply(OpR, 1'(i), 12);
    chk("halted sticky", int'(halted_o), 1);
`else
    apply(OpIll, 0, 0);
    chk("no halt", int'(halted_o), 0);
`endif
    pulse_reset();
    chk("halt cleared", int'(halted_o), 0);

    ops = '{OpLw, OpSw, OpR, OpAddi, OpBeq, OpJ, OpIll};
    for (int n = 0; n < 300; n++) begin
      logic [5:0] op;
      int k;
`ifdef MC_ILLEGAL_OP_TRAP_EN
      k = int'($urandom_range(0, 5));
`else
      k = int'($urandom_range(0, 6));
`endif
      op = ops[k];
      inst_path(op, p);
      foreach (p[j]) apply(op, 1'($urandom), p[j]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected completion");
    $fatal(1);
  end

endmodule
